// File: rtl/full_subtractor_64bit_serial_pkg.sv
// Shared types and sizing helpers for the chunk-serial 64-bit subtractor.
package full_subtractor_64bit_serial_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    localparam int unsigned DefaultWidth = 64;
    localparam int unsigned DefaultChunk = 8;

    function automatic int unsigned calc_nchunk(input int unsigned width,
                                                input int unsigned chunk);
        return width / chunk;
    endfunction

    // A single-chunk configuration still needs a 1-bit counter to stay legal.
    function automatic int unsigned calc_cnt_width(input int unsigned width,
                                                   input int unsigned chunk);
        int unsigned n;
        n = width / chunk;
        return (n > 1) ? unsigned'($clog2(n)) : 1;
    endfunction

endpackage

// File: rtl/full_subtractor_64bit_serial_if.sv
// Operand/result handshake bundle; slave is the subtractor, master the client.
interface full_subtractor_64bit_serial_if #(
    parameter int unsigned WIDTH = full_subtractor_64bit_serial_pkg::DefaultWidth
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             overflow;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout, overflow
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout, overflow
    );

endinterface

// File: rtl/full_subtractor_64bit_serial_full_subtractor_1bit.sv
// One-bit full-subtractor cell: d = x - y - bi with borrow-out bo.
module full_subtractor_1bit (
    input  logic i_x,
    input  logic i_y,
    input  logic i_bi,
    output logic o_d,
    output logic o_bo
);

    assign o_d  = i_x ^ i_y ^ i_bi;
    assign o_bo = (~i_x & i_y) | (~(i_x ^ i_y) & i_bi);

endmodule

// File: rtl/full_subtractor_64bit_serial.sv
// Chunk-serial subtractor: diff = a - b - bin, CHUNK bits per cycle, LS chunk first,
// borrow carried in a register between chunks; result held until out_ready.
module full_subtractor_64bit_serial
    import full_subtractor_64bit_serial_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth,
    parameter int unsigned CHUNK = DefaultChunk
) (
    input logic                         clk,
    input logic                         rst_n,
    full_subtractor_64bit_serial_if.slave bus
);

    localparam int unsigned      NCHUNK   = calc_nchunk(WIDTH, CHUNK);
    localparam int unsigned      CNT_W    = calc_cnt_width(WIDTH, CHUNK);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);

    if (WIDTH % CHUNK != 0) begin : g_bad_params
        $error("full_subtractor_64bit_serial: WIDTH must be a multiple of CHUNK");
    end

    state_e           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;
    logic             r_bout;
    logic             r_overflow;
    logic [CNT_W-1:0] r_cnt;

    logic [31:0]      w_base;
    logic [CHUNK-1:0] w_x;
    logic [CHUNK-1:0] w_y;
    logic [CHUNK-1:0] w_d;
    logic             w_chunk_bout;
    logic             w_last;

    assign w_base = 32'(r_cnt) * CHUNK;
    assign w_x    = r_a[w_base +: CHUNK];
    assign w_y    = r_b[w_base +: CHUNK];
    assign w_last = (r_cnt == LAST_CNT);

    // Borrow ripples through per-stage nets so the chain never loops back on one vector.
    for (genvar i = 0; i < CHUNK; i++) begin : g_cell
        logic w_bi;
        logic w_bo;

        if (i == 0) begin : g_first
            assign w_bi = r_borrow;
        end else begin : g_rest
            assign w_bi = g_cell[i-1].w_bo;
        end

        full_subtractor_1bit u_cell (
            .i_x  (w_x[i]),
            .i_y  (w_y[i]),
            .i_bi (w_bi),
            .o_d  (w_d[i]),
            .o_bo (w_bo)
        );
    end

    assign w_chunk_bout = g_cell[CHUNK-1].w_bo;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_a        <= '0;
            r_b        <= '0;
            r_diff     <= '0;
            r_borrow   <= 1'b0;
            r_bout     <= 1'b0;
            r_overflow <= 1'b0;
            r_cnt      <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (bus.in_valid) begin
                        r_a      <= bus.a;
                        r_b      <= bus.b;
                        r_borrow <= bus.bin;
                        r_cnt    <= '0;
                        r_state  <= StRun;
                    end
                end
                StRun: begin
                    r_diff[w_base +: CHUNK] <= w_d;
                    r_borrow                <= w_chunk_bout;
                    r_cnt                   <= r_cnt + 1'b1;
                    if (w_last) begin
                        // MSB of the final slice is the sign of the full difference.
                        r_bout     <= w_chunk_bout;
                        r_overflow <= (r_a[WIDTH-1] != r_b[WIDTH-1]) &&
                                      (w_d[CHUNK-1] != r_a[WIDTH-1]);
                        r_cnt      <= '0;
                        r_state    <= StDone;
                    end
                end
                StDone: begin
                    if (bus.out_ready) begin
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == StIdle);
    assign bus.out_valid = (r_state == StDone);
    assign bus.diff      = r_diff;
    assign bus.bout      = r_bout;
    assign bus.overflow  = r_overflow;

endmodule

// File: tb/tb_full_subtractor_64bit_serial.sv
// Scoreboard bench for full_subtractor_64bit_serial: directed vectors, backpressure, reset abort.
module tb_full_subtractor_64bit_serial;

    localparam int unsigned W   = 64;
    localparam int unsigned NCH = 8;

    typedef struct {
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
    } exp_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   n_checks = 0;
    int   n_errs   = 0;
    logic prev_ov  = 1'b0;
    exp_t exp_q[$];
    int   acc_q[$];
    vec_t vecs[8];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    full_subtractor_64bit_serial_if #(.WIDTH(W)) ifc ();

    full_subtractor_64bit_serial #(
        .WIDTH (W),
        .CHUNK (NCH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: samples at negedge; inputs only change just after posedge.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_ov = 1'b0;
        end else begin
            if (ifc.in_valid && ifc.in_ready) acc_q.push_back(cyc + 1);
            if (ifc.out_valid && !prev_ov) begin
                if (acc_q.size() == 0) begin
                    chk("latency_no_accept", 64'(cyc), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    chk("latency", 64'(cyc - acc_q.pop_front()), 64'(NCH));
                end
            end
            if (ifc.out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", ifc.diff, 64'hx);
                end else begin
                    chk("diff", ifc.diff, exp_q[0].d);
                    chk("bout", 64'(ifc.bout), 64'(exp_q[0].bo));
                    chk("overflow", 64'(ifc.overflow), 64'(exp_q[0].ov));
                    if (ifc.out_ready) void'(exp_q.pop_front());
                end
            end
            prev_ov = ifc.out_valid;
        end
    end

    task automatic wait_accept();
        int n;
        n = 0;
        @(negedge clk);
        while (!ifc.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!ifc.in_ready) chk("accept_timeout", 64'(ifc.in_ready), 64'd1);
        @(posedge clk);
        #1;
        ifc.in_valid = 1'b0;
        ifc.a        = 64'hDEAD_BEEF_CAFE_F00D;
        ifc.b        = 64'h0123_4567_89AB_CDEF;
        ifc.bin      = 1'b1;
    endtask

    task automatic drive(input vec_t v);
        ifc.a        = v.a;
        ifc.b        = v.b;
        ifc.bin      = v.bin;
        ifc.in_valid = 1'b1;
        exp_q.push_back('{d: v.d, bo: v.bo, ov: v.ov});
    endtask

    task automatic send(input vec_t v);
        @(posedge clk);
        #1;
        drive(v);
        wait_accept();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t v;
        int   n;

        vecs[0] = '{a: 64'd10, b: 64'd3, bin: 1'b0, d: 64'd7, bo: 1'b0, ov: 1'b0};
        vecs[1] = '{a: 64'h100, b: 64'd1, bin: 1'b0, d: 64'hFF, bo: 1'b0, ov: 1'b0};
        vecs[2] = '{a: 64'd0, b: 64'd1, bin: 1'b0, d: 64'hFFFF_FFFF_FFFF_FFFF, bo: 1'b1,
                    ov: 1'b0};
        vecs[3] = '{a: 64'h8000_0000_0000_0000, b: 64'd1, bin: 1'b0,
                    d: 64'h7FFF_FFFF_FFFF_FFFF, bo: 1'b0, ov: 1'b1};
        vecs[4] = '{a: 64'h7FFF_FFFF_FFFF_FFFF, b: 64'hFFFF_FFFF_FFFF_FFFF, bin: 1'b0,
                    d: 64'h8000_0000_0000_0000, bo: 1'b1, ov: 1'b1};
        vecs[5] = '{a: 64'd5, b: 64'd5, bin: 1'b1, d: 64'hFFFF_FFFF_FFFF_FFFF, bo: 1'b1,
                    ov: 1'b0};
        vecs[6] = '{a: 64'd0, b: 64'd0, bin: 1'b1, d: 64'hFFFF_FFFF_FFFF_FFFF, bo: 1'b1,
                    ov: 1'b0};
        vecs[7] = '{a: 64'hFFFF_FFFF_FFFF_FFFE, b: 64'd3, bin: 1'b0,
                    d: 64'hFFFF_FFFF_FFFF_FFFB, bo: 1'b0, ov: 1'b0};

        ifc.in_valid  = 1'b0;
        ifc.a         = '0;
        ifc.b         = '0;
        ifc.bin       = 1'b0;
        ifc.out_ready = 1'b1;

        repeat (2) @(negedge clk);
        chk("rst_in_ready", 64'(ifc.in_ready), 64'd1);
        chk("rst_out_valid", 64'(ifc.out_valid), 64'd0);
        chk("rst_diff", ifc.diff, 64'd0);
        chk("rst_bout", 64'(ifc.bout), 64'd0);
        chk("rst_overflow", 64'(ifc.overflow), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            send(vecs[i]);
            drain();
        end

        // Backpressure: result must hold while new operands wait on in_ready.
        @(posedge clk);
        #1;
        ifc.out_ready = 1'b0;
        v = '{a: 64'd100, b: 64'd58, bin: 1'b1, d: 64'd41, bo: 1'b0, ov: 1'b0};
        send(v);
        n = 0;
        while (!ifc.out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("bp_reach_done", 64'(ifc.out_valid), 64'd1);
        @(posedge clk);
        #1;
        v = '{a: 64'h1234_5678_9ABC_DEF0, b: 64'h0FED_CBA9_8765_4321, bin: 1'b0,
              d: 64'h0246_8ACF_1357_9BCF, bo: 1'b0, ov: 1'b0};
        drive(v);
        repeat (20) begin
            @(negedge clk);
            chk("bp_out_valid", 64'(ifc.out_valid), 64'd1);
            chk("bp_in_ready", 64'(ifc.in_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        ifc.out_ready = 1'b1;
        wait_accept();
        drain();

        // Reset mid-RUN aborts; no result for the aborted operation may appear.
        v = '{a: 64'h1111, b: 64'h2222, bin: 1'b0, d: 64'd0, bo: 1'b0, ov: 1'b0};
        send(v);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        acc_q.delete();
        @(negedge clk);
        chk("abort_out_valid", 64'(ifc.out_valid), 64'd0);
        chk("abort_diff", ifc.diff, 64'd0);
        chk("abort_in_ready", 64'(ifc.in_ready), 64'd1);
        chk("abort_bout", 64'(ifc.bout), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        v = '{a: 64'd20, b: 64'd7, bin: 1'b0, d: 64'd13, bo: 1'b0, ov: 1'b0};
        send(v);
        drain();

        repeat (3) @(negedge clk);
        chk("final_idle_in_ready", 64'(ifc.in_ready), 64'd1);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
